// File: rtl/ccff_loader.sv
// ccff_loader: serialises bitstream bytes onto the configuration chain and reads back ccff_tail
module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic [7:0] tail_data,
  output logic       tail_valid,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, FLUSH} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [7:0] sh, tsh;
  logic [2:0] idx, tcnt;
  logic phase_end, enter_low, sample;
  assign phase_end = div == DW'(CLK_DIV - 1);
  assign in_ready = state == FETCH;
  assign busy = state != IDLE;
  assign enter_low = state_nx == LOW && state != LOW;
  assign sample = state == LOW && state_nx == HIGH;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state; abort outranks every transition once a load is running
  always_comb begin
    state_nx = state;
    if (state != IDLE && abort) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = start && !abort ? FETCH : IDLE;
        FETCH: state_nx = in_valid ? LOW : FETCH;
        LOW: state_nx = phase_end ? HIGH : LOW;
        HIGH: state_nx = !phase_end ? HIGH : cnt == CW'(CHAIN_LEN - 1) ? FLUSH : idx == 3'd0 ? FETCH : LOW;
        default: state_nx = IDLE;
      endcase
  end
  // phase timer, byte shifter, chain outputs and readback assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      cnt <= '0;
      sh <= '0;
      tsh <= '0;
      idx <= '0;
      tcnt <= '0;
      prog_clk <= 1'b0;
      ccff_head <= 1'b0;
      tail_data <= '0;
      tail_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      div <= (state == LOW || state == HIGH) && !phase_end ? div + 1'b1 : '0;
      prog_clk <= state_nx == HIGH;
      tail_valid <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        tsh <= '0;
        tcnt <= '0;
      end
      if (enter_low) begin
        ccff_head <= state == FETCH ? in_data[7] : sh[7];
        sh <= state == FETCH ? {in_data[6:0], 1'b0} : {sh[6:0], 1'b0};
        idx <= state == FETCH ? 3'd7 : idx - 1'b1;
      end
      if (state == HIGH && phase_end) cnt <= cnt + 1'b1;
      if (sample) begin
        tsh <= {tsh[6:0], ccff_tail};
        tcnt <= tcnt + 1'b1;
        if (tcnt == 3'd7) begin
          tail_data <= {tsh[6:0], ccff_tail};
          tail_valid <= 1'b1;
        end
      end
      if (state == FLUSH && !abort) begin
        done <= 1'b1;
        if (tcnt != 3'd0) begin
          tail_data <= tsh << (4'd8 - {1'b0, tcnt});
          tail_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed and randomized checking of ccff_loader against a bit-timeline model
module tb_ccff_loader;
  localparam int L = 12;
  localparam int D = 2;
  logic clk = 0, reset = 1, start = 0, abort = 0, in_valid = 0, ccff_tail = 0;
  logic [7:0] in_data = 0;
  logic in_ready, prog_clk, ccff_head, tail_valid, busy, done;
  logic [7:0] tail_data;
  int passes = 0, checks = 0, cyc = 0;
  bit m_busy = 0, m_wait = 0, m_flush = 0;
  int m_k = 0, pos = 0, ns = 0;
  logic [7:0] mbyte = 0, tacc = 0, e_td = 0;
  logic e_pclk = 0, e_head = 0, e_tv = 0, e_done = 0;
  int rises = 0, rdy_cnt = 0, done_cyc = -1;
  logic [11:0] head_log = 0;
  logic [7:0] tv_log[$];
  logic pclk_q = 0;

  ccff_loader #(.CHAIN_LEN(L), .CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .tail_data(tail_data), .tail_valid(tail_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got %0h expected %0h", name, got, want);
  endtask

  // reference: bit k of the load occupies 2*D cycles (pos 0..D-1 low, D..2D-1 high)
  always @(posedge clk) begin
    cyc++;
    e_tv = 0;
    e_done = 0;
    if (reset) begin
      m_busy = 0;
      e_head = 0;
      e_td = 0;
    end else if (m_busy && abort) m_busy = 0;
    else if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1;
        m_wait = 1;
        m_flush = 0;
        m_k = 0;
        ns = 0;
        tacc = 0;
      end
    end else if (m_flush) begin
      m_busy = 0;
      e_done = 1;
      if (ns % 8 != 0) begin
        e_td = tacc << (8 - ns % 8);
        e_tv = 1;
      end
    end else if (m_wait) begin
      if (in_valid) begin
        mbyte = in_data;
        m_wait = 0;
        pos = 0;
        e_head = mbyte[7];
      end
    end else begin
      if (pos == D - 1) begin
        tacc = {tacc[6:0], ccff_tail};
        ns++;
        if (ns % 8 == 0) begin
          e_td = tacc;
          e_tv = 1;
        end
      end
      if (pos == 2 * D - 1) begin
        m_k++;
        if (m_k == L) m_flush = 1;
        else if (m_k % 8 == 0) m_wait = 1;
        else begin
          pos = 0;
          e_head = mbyte[7 - m_k % 8];
        end
      end else pos++;
    end
    e_pclk = m_busy && !m_wait && !m_flush && pos >= D;
  end

  // per-cycle compare against the model, plus an event log for the directed checks
  always @(negedge clk) begin
    logic [13:0] got, want;
    got = {prog_clk, ccff_head, in_ready, tail_data, tail_valid, busy, done};
    want = {e_pclk, e_head, m_busy && m_wait, e_td, e_tv, m_busy, e_done};
    checks++;
    if (got === want) passes++;
    else $display("FAIL outputs cycle %0d got %b expected %b", cyc, got, want);
    if (prog_clk && !pclk_q) begin
      rises++;
      head_log = {head_log[10:0], ccff_head};
    end
    pclk_q = prog_clk;
    if (tail_valid) tv_log.push_back(tail_data);
    if (done) done_cyc = cyc;
    if (in_ready) rdy_cnt++;
  end

  initial begin
    logic [11:0] pat;
    int t0, r0, n0, d0, n, stall;
    pat = 12'b0011_1100_1011;
    stall = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {prog_clk, ccff_head, in_ready, tail_data, tail_valid, busy, done}, 0);
    reset = 0;
    @(negedge clk);
    t0 = cyc;
    r0 = rises;
    n0 = tv_log.size();
    d0 = rdy_cnt;
    start = 1;
    in_valid = 1;
    in_data = 8'hA5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    in_data = 8'h9F;
    repeat (70) begin
      ccff_tail = m_k < L ? pat[L - 1 - m_k] : 1'b0;
      start = (cyc - t0 == 10);
      @(negedge clk);
    end
    in_valid = 0;
    check("edge_count", rises - r0, 12);
    check("head_bits", head_log, 12'hA59);
    check("tail_pulses", tv_log.size() - n0, 2);
    check("tail_byte", tv_log.size() > n0 ? tv_log[n0] : 8'h00, 8'h3C);
    check("tail_flush", tv_log.size() > n0 + 1 ? tv_log[n0 + 1] : 8'h00, 8'hB0);
    check("done_cycle", done_cyc - t0, 52);
    check("ready_cycles", rdy_cnt - d0, 2);
    start = 1;
    in_valid = 1;
    in_data = 8'($urandom);
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(m_k == 3 && e_pclk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", n < 200, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_outputs", {prog_clk, busy, done}, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(m_k == 2 && m_busy && !m_wait && !m_flush && !e_pclk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_reached", n < 200, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("reset_mid_load", {prog_clk, ccff_head, in_ready, tail_data, tail_valid, busy, done}, 0);
    for (int i = 0; i < 6000; i++) begin
      start = $urandom_range(0, 15) == 0;
      abort = $urandom_range(0, 299) == 0;
      reset = $urandom_range(0, 999) == 0;
      if (stall > 0) begin
        in_valid = 0;
        stall--;
      end else begin
        in_valid = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 49) == 0) stall = 20;
      end
      in_data = 8'($urandom);
      ccff_tail = 1'($urandom);
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
